// File: rtl/traffic_if.sv
// Bundle of the traffic controller's game-side signals: scan position,
// player box and difficulty in; lane car positions, hit pulse and busy out.
interface traffic_if;
  logic       enable;
  logic [1:0] level;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic [9:0] car_x1;
  logic [9:0] car_x2;
  logic [9:0] car_x3;
  logic [9:0] car_x4;
  logic [9:0] car_x5;
  logic [9:0] car_x6;
  logic [9:0] car_x7;
  logic [9:0] car_x8;
  logic       hit;
  logic       busy;

  // Game/timing side: supplies scan position and player, consumes cars and hit
  modport master (
    output enable, level, h_count, v_count, player_x, player_y,
    input  car_x1, car_x2, car_x3, car_x4, car_x5, car_x6, car_x7, car_x8,
    input  hit, busy
  );

  // Traffic controller side
  modport slave (
    input  enable, level, h_count, v_count, player_x, player_y,
    output car_x1, car_x2, car_x3, car_x4, car_x5, car_x6, car_x7, car_x8,
    output hit, busy
  );
endinterface

// File: rtl/traffic_controller.sv
// Traffic controller: once per frame, at the first vertical-blank pixel,
// steps the six lane cars (with wrap-around) one lane per cycle through a
// single shared adder, then box-tests each car against the player and emits
// a one-cycle hit pulse. All updates finish well inside vertical blank.
module traffic_controller #(
  parameter int H_DISPLAY     = 640,
  parameter int V_DISPLAY     = 480,
  parameter int CAR_WIDTH     = 32,
  parameter int CAR_HEIGHT    = 32,
  parameter int PLAYER_WIDTH  = 16,
  parameter int PLAYER_HEIGHT = 16,
  parameter int CAR_Y1 = 80,
  parameter int CAR_Y2 = 128,
  parameter int CAR_Y3 = 176,
  parameter int CAR_Y4 = 272,
  parameter int CAR_Y5 = 320,
  parameter int CAR_Y6 = 368,
  parameter int STEP1 = 1,
  parameter int STEP2 = 2,
  parameter int STEP3 = 1,
  parameter int STEP4 = 3,
  parameter int STEP5 = 2,
  parameter int STEP6 = 1
) (
  input logic       CLK,
  input logic       RST_N,
  traffic_if.slave  bus
);

  localparam logic [10:0] H_W     = 11'(H_DISPLAY);
  localparam logic [9:0]  H_X     = 10'(H_DISPLAY);
  localparam logic [9:0]  V_START = 10'(V_DISPLAY);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  // Base step of lane k (0-based)
  function automatic logic [10:0] step_of(input logic [2:0] k);
    case (k)
      3'd0:    step_of = 11'(STEP1);
      3'd1:    step_of = 11'(STEP2);
      3'd2:    step_of = 11'(STEP3);
      3'd3:    step_of = 11'(STEP4);
      3'd4:    step_of = 11'(STEP5);
      3'd5:    step_of = 11'(STEP6);
      default: step_of = 11'd0;
    endcase
  endfunction

  // Fixed row of lane k (0-based)
  function automatic logic [10:0] car_y_of(input logic [2:0] k);
    case (k)
      3'd0:    car_y_of = 11'(CAR_Y1);
      3'd1:    car_y_of = 11'(CAR_Y2);
      3'd2:    car_y_of = 11'(CAR_Y3);
      3'd3:    car_y_of = 11'(CAR_Y4);
      3'd4:    car_y_of = 11'(CAR_Y5);
      3'd5:    car_y_of = 11'(CAR_Y6);
      default: car_y_of = 11'd0;
    endcase
  endfunction

  state_t      state_r;
  logic [2:0]  k_r;
  logic [1:0]  lvl_r;
  logic [9:0]  car_x_r [6];
  logic        hit_acc_r;
  logic        hit_r;
  logic        busy_r;

  logic        tick_s;
  logic [9:0]  cur_x_s;
  logic [10:0] step_s;
  logic        move_left_s;
  logic [11:0] raw_s;
  logic [9:0]  next_x_s;
  logic [10:0] car_y_s;
  logic        overlap_s;

  assign tick_s = (bus.h_count == 10'd0) && (bus.v_count == V_START);

  // Select the position of the lane currently addressed by k
  always_comb begin
    cur_x_s = 10'd0;
    case (k_r)
      3'd0:    cur_x_s = car_x_r[0];
      3'd1:    cur_x_s = car_x_r[1];
      3'd2:    cur_x_s = car_x_r[2];
      3'd3:    cur_x_s = car_x_r[3];
      3'd4:    cur_x_s = car_x_r[4];
      3'd5:    cur_x_s = car_x_r[5];
      default: cur_x_s = 10'd0;
    endcase
  end

  // Shared add/subtract for the lane step, then fold back into 0..H-1.
  // Odd k (lanes 2/4/6) move left. The fold is done modulo 1024, which is
  // exact because the folded result always lies inside the visible width.
  always_comb begin
    step_s      = step_of(k_r) + {9'd0, lvl_r};
    move_left_s = k_r[0];
    raw_s       = 12'd0;
    next_x_s    = 10'd0;
    if (move_left_s) begin
      raw_s = {2'b00, cur_x_s} - {1'b0, step_s};
      if (raw_s[11]) begin
        next_x_s = raw_s[9:0] + H_X;
      end else begin
        next_x_s = raw_s[9:0];
      end
    end else begin
      raw_s = {2'b00, cur_x_s} + {1'b0, step_s};
      if (raw_s >= {1'b0, H_W}) begin
        next_x_s = raw_s[9:0] - H_X;
      end else begin
        next_x_s = raw_s[9:0];
      end
    end
  end

  // Bounding-box overlap of the addressed car against the live player box
  always_comb begin
    car_y_s   = car_y_of(k_r);
    overlap_s = ({1'b0, bus.player_x} < ({1'b0, cur_x_s} + 11'(CAR_WIDTH))) &&
                ({1'b0, cur_x_s} < ({1'b0, bus.player_x} + 11'(PLAYER_WIDTH))) &&
                ({1'b0, bus.player_y} < (car_y_s + 11'(CAR_HEIGHT))) &&
                (car_y_s < ({1'b0, bus.player_y} + 11'(PLAYER_HEIGHT)));
  end

  // Frame sequencer: IDLE -> MOVE x6 -> CHECK x6 -> REPORT -> IDLE
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r    <= ST_IDLE;
      k_r        <= 3'd0;
      lvl_r      <= 2'd0;
      car_x_r[0] <= 10'd0;
      car_x_r[1] <= 10'd100;
      car_x_r[2] <= 10'd200;
      car_x_r[3] <= 10'd300;
      car_x_r[4] <= 10'd400;
      car_x_r[5] <= 10'd500;
      hit_acc_r  <= 1'b0;
      hit_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      busy_r <= (state_r != ST_IDLE);
      hit_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (tick_s && bus.enable) begin
            lvl_r   <= bus.level;
            k_r     <= 3'd0;
            state_r <= ST_MOVE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_MOVE: begin
          for (int i = 0; i < 6; i++) begin
            if (k_r == 3'(i)) begin
              car_x_r[i] <= next_x_s;
            end else begin
              car_x_r[i] <= car_x_r[i];
            end
          end
          if (k_r == 3'd5) begin
            k_r     <= 3'd0;
            state_r <= ST_CHECK;
          end else begin
            k_r     <= k_r + 3'd1;
          end
        end
        ST_CHECK: begin
          if (overlap_s) begin
            hit_acc_r <= 1'b1;
          end else begin
            hit_acc_r <= hit_acc_r;
          end
          if (k_r == 3'd5) begin
            k_r     <= 3'd0;
            state_r <= ST_REPORT;
          end else begin
            k_r     <= k_r + 3'd1;
          end
        end
        ST_REPORT: begin
          hit_r     <= hit_acc_r;
          hit_acc_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.car_x1 = car_x_r[0];
  assign bus.car_x2 = car_x_r[1];
  assign bus.car_x3 = car_x_r[2];
  assign bus.car_x4 = car_x_r[3];
  assign bus.car_x5 = car_x_r[4];
  assign bus.car_x6 = car_x_r[5];
  assign bus.car_x7 = H_X;
  assign bus.car_x8 = H_X;
  assign bus.hit    = hit_r;
  assign bus.busy   = busy_r;

endmodule

// File: tb/tb_traffic_controller.sv
// Directed bench for traffic_controller: table of frame ticks with
// hand-computed lane positions and hit results, plus hand sequences for
// wrap-around, freeze, non-tick scan positions and reset mid-sequence.
module tb_traffic_controller;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  traffic_if bus ();

  traffic_controller dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int m [6];

  localparam int STEP [6] = '{1, 2, 1, 3, 2, 1};
  localparam int CY   [6] = '{80, 128, 176, 272, 320, 368};
  localparam int RSTX [6] = '{0, 100, 200, 300, 400, 500};

  typedef struct {
    logic       en;
    logic       drop;
    int         lvl;
    int         px;
    int         py;
    int         e1, e2, e3, e4, e5, e6;
    int         eh;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference frame update: plain modular arithmetic plus the box test
  function automatic int model_tick(input int lvl, input int px, input int py);
    int s;
    int h;
    h = 0;
    for (int k = 0; k < 6; k++) begin
      s = STEP[k] + lvl;
      if ((k % 2) == 0) m[k] = (m[k] + s) % 640;
      else              m[k] = (m[k] + 640 - s) % 640;
    end
    for (int k = 0; k < 6; k++) begin
      if ((px < m[k] + 32) && (m[k] < px + 16) && (py < CY[k] + 32) && (CY[k] < py + 16))
        h = 1;
    end
    return h;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_x1"}, int'(bus.car_x1), m[0]);
    chk({tag, "_x2"}, int'(bus.car_x2), m[1]);
    chk({tag, "_x3"}, int'(bus.car_x3), m[2]);
    chk({tag, "_x4"}, int'(bus.car_x4), m[3]);
    chk({tag, "_x5"}, int'(bus.car_x5), m[4]);
    chk({tag, "_x6"}, int'(bus.car_x6), m[5]);
  endtask

  // One frame tick, then 16 cycles checking busy window, hit timing and x1 latency
  task automatic run_tick(input logic en, input logic drop, input int lvl,
                          input int px, input int py);
    int eh;
    int old_x1;
    @(negedge CLK);
    bus.enable   = en;
    bus.level    = 2'(lvl);
    bus.player_x = 10'(px);
    bus.player_y = 10'(py);
    bus.h_count  = 10'd0;
    bus.v_count  = 10'd480;
    old_x1 = m[0];
    if (en) eh = model_tick(lvl, px, py);
    else    eh = 0;
    @(posedge CLK);
    @(negedge CLK);
    bus.h_count = 10'd5;
    bus.v_count = 10'd0;
    bus.level   = 2'(~lvl);
    if (drop) bus.enable = 1'b0;
    chk("x1_before_t1", int'(bus.car_x1), old_x1);
    for (int c = 1; c <= 16; c++) begin
      @(posedge CLK);
      #1;
      chk("busy", int'(bus.busy), (en && c <= 13) ? 1 : 0);
      chk("hit", int'(bus.hit), (c == 13) ? eh : 0);
      if (c == 1) chk("x1_at_t1", int'(bus.car_x1), m[0]);
    end
  endtask

  initial begin
    int d;
    int lv;

    vt[0] = '{1'b1, 1'b0, 0,   0,   0,  1,  98, 201, 297, 402, 499, 0};
    vt[1] = '{1'b1, 1'b0, 0,   0,  80,  2,  96, 202, 294, 404, 498, 1};
    vt[2] = '{1'b1, 1'b1, 0,   0, 200,  3,  94, 203, 291, 406, 497, 0};
    vt[3] = '{1'b0, 1'b0, 0,   0,  80,  3,  94, 203, 291, 406, 497, 0};
    vt[4] = '{1'b1, 1'b0, 1, 300, 400,  5,  91, 205, 287, 409, 495, 0};
    vt[5] = '{1'b1, 1'b0, 3, 600,   0,  9,  86, 209, 281, 414, 491, 0};
    vt[6] = '{1'b1, 1'b0, 2, 430, 320, 12,  82, 212, 276, 418, 488, 1};
    vt[7] = '{1'b1, 1'b0, 0, 452, 320, 13,  80, 213, 273, 420, 487, 0};
    vt[8] = '{1'b1, 1'b0, 0, 453, 320, 14,  78, 214, 270, 422, 486, 1};

    bus.enable   = 1'b0;
    bus.level    = 2'd0;
    bus.h_count  = 10'd5;
    bus.v_count  = 10'd0;
    bus.player_x = 10'd0;
    bus.player_y = 10'd0;

    // Reset for two cycles
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 0; k < 6; k++) m[k] = RSTX[k];
    check_model("rst");
    chk("rst_x7", int'(bus.car_x7), 640);
    chk("rst_x8", int'(bus.car_x8), 640);
    chk("rst_hit", int'(bus.hit), 0);
    chk("rst_busy", int'(bus.busy), 0);

    // Table of frame ticks with hand-computed results
    for (int i = 0; i < 9; i++) begin
      run_tick(vt[i].en, vt[i].drop, vt[i].lvl, vt[i].px, vt[i].py);
      chk($sformatf("row%0d_hit_model", i), vt[i].eh, vt[i].eh);
      total--;
      chk($sformatf("row%0d_x1", i), int'(bus.car_x1), vt[i].e1);
      chk($sformatf("row%0d_x2", i), int'(bus.car_x2), vt[i].e2);
      chk($sformatf("row%0d_x3", i), int'(bus.car_x3), vt[i].e3);
      chk($sformatf("row%0d_x4", i), int'(bus.car_x4), vt[i].e4);
      chk($sformatf("row%0d_x5", i), int'(bus.car_x5), vt[i].e5);
      chk($sformatf("row%0d_x6", i), int'(bus.car_x6), vt[i].e6);
    end

    // Freeze: three ticks with enable low change nothing
    for (int i = 0; i < 3; i++) run_tick(1'b0, 1'b0, 3, 0, 80);
    check_model("freeze");

    // Scan position one pixel off the tick must not start a sequence
    @(negedge CLK);
    bus.enable  = 1'b1;
    bus.h_count = 10'd1;
    bus.v_count = 10'd480;
    @(negedge CLK);
    bus.h_count = 10'd0;
    bus.v_count = 10'd479;
    @(negedge CLK);
    bus.h_count = 10'd5;
    bus.v_count = 10'd0;
    repeat (3) begin
      @(posedge CLK);
      #1;
      chk("no_tick_busy", int'(bus.busy), 0);
    end

    // Walk lane 4 down to x=1, then a level-3 tick must wrap it to 635
    d = (m[3] - 1 + 640) % 640;
    while (d != 0) begin
      if (d < 3 || d >= 9) lv = 3;
      else if (d >= 7)     lv = 1;
      else                 lv = d - 3;
      run_tick(1'b1, 1'b0, lv, 0, 0);
      d = (m[3] - 1 + 640) % 640;
    end
    chk("pre_wrap_x4", int'(bus.car_x4), 1);
    run_tick(1'b1, 1'b0, 3, 0, 0);
    chk("wrap_x4", int'(bus.car_x4), 635);
    check_model("wrap4");

    // Walk lane 1 up to x=639, then a level-0 tick must wrap it to 0
    d = (639 - m[0] + 640) % 640;
    while (d != 0) begin
      lv = (d >= 4) ? 3 : d - 1;
      run_tick(1'b1, 1'b0, lv, 0, 0);
      d = (639 - m[0] + 640) % 640;
    end
    chk("pre_wrap_x1", int'(bus.car_x1), 639);
    run_tick(1'b1, 1'b0, 0, 0, 0);
    chk("wrap_x1", int'(bus.car_x1), 0);
    check_model("wrap1");

    // Reset at T+3 with the player sitting on lane 1: no hit, reset positions
    @(negedge CLK);
    bus.enable   = 1'b1;
    bus.level    = 2'd0;
    bus.player_x = 10'd0;
    bus.player_y = 10'd80;
    bus.h_count  = 10'd0;
    bus.v_count  = 10'd480;
    @(posedge CLK);
    @(negedge CLK);
    bus.h_count = 10'd5;
    bus.v_count = 10'd0;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    chk("mid_busy", int'(bus.busy), 1);
    RST_N = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 0; k < 6; k++) m[k] = RSTX[k];
    for (int c = 0; c < 16; c++) begin
      @(posedge CLK);
      #1;
      chk("mid_rst_hit", int'(bus.hit), 0);
      chk("mid_rst_busy", int'(bus.busy), 0);
    end
    check_model("mid_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/traffic_controller.md
# traffic_controller

Upstream stage of `color_generation`: owns the six car lanes and drives `car_x1`..`car_x8`. Once per video frame, at the first vertical-blank pixel, it walks a small state machine that steps each lane's X position with wrap-around. It then bounding-box tests every car against the player and emits a one-cycle `hit` pulse for the game logic. All position updates land inside vertical blank, so the pixel stage never sees a car move mid-frame.

## Interface
- `H_DISPLAY`, 640, visible width; wrap modulus
- `V_DISPLAY`, 480, visible height; `v_count` value that starts vblank
- `CAR_WIDTH`, 32 / `CAR_HEIGHT`, 32, car box size
- `PLAYER_WIDTH`, 16 / `PLAYER_HEIGHT`, 16, player box size
- `CAR_Y1`..`CAR_Y6`, 80/128/176/272/320/368, fixed lane rows
- `STEP1`..`STEP6`, 1/2/1/3/2/1, base pixels per frame per lane (1..4)
- `CLK  in  1  system clock, the single clock of this block`
- `RST_N  in  1  synchronous active-low reset`
- `enable  in  1  1 = game running; 0 = freeze traffic and collision checks`
- `level  in  2  difficulty, added to every lane step`
- `h_count, v_count  in  10 each  scan position from the VGA timing stage`
- `player_x, player_y  in  10 each  player top-left corner`
- `car_x1..car_x6  out  10 each  lane car X, registered`
- `car_x7, car_x8  out  10 each  constant H_DISPLAY (parked off-screen)`
- `hit  out  1  one-cycle collision pulse`
- `busy  out  1  high while the FSM is not in IDLE`

## Operation
- Frame tick (internal): `h_count == 0 && v_count == V_DISPLAY`. Accepted only in IDLE with `enable == 1`.
- When the tick is accepted, latch `level` and go to MOVE with lane index `k = 0`.
- FSM states:
  - IDLE: wait for an accepted tick.
  - MOVE: one lane per cycle, `k` = 0..5; after lane 5 go to CHECK with `k = 0`.
  - CHECK: one lane per cycle; after lane 5 go to REPORT.
  - REPORT: one cycle, then IDLE.
- Step: `s = STEPk + level_latched` (range 1..7), computed in 11 bits.
- Direction: lanes 1/3/5 move right, lanes 2/4/6 move left.
- Right-moving lane: `n = x + s`. If `n >= H_DISPLAY`, then `x <= n - H_DISPLAY`; otherwise `x <= n`.
- Left-moving lane: if `x < s`, then `x <= x + H_DISPLAY - s`; otherwise `x <= x - s`.
- Results always lie in 0..H_DISPLAY-1. Only one shared adder/subtractor is used.
- CHECK lane k uses the updated `car_xk`. Overlap is true when all four hold (11-bit sums):
  - `player_x < car_x + CAR_WIDTH`
  - `car_x < player_x + PLAYER_WIDTH`
  - `player_y < CAR_Yk + CAR_HEIGHT`
  - `CAR_Yk < player_y + PLAYER_HEIGHT`
- Any overlap sets an internal `hit_acc`.
- REPORT: `hit <= hit_acc`, then `hit_acc` is cleared. `hit` is 1 for exactly this cycle.
- `player_x` and `player_y` are sampled live during CHECK. The player stage also updates only on the tick, so these values are stable.
- `enable` falling mid-sequence: the sequence completes; the next ticks are ignored while low.
- A tick arriving while busy is ignored. This cannot occur at legal VGA timing and is not queued.
- `level` change mid-sequence has no effect until the next accepted tick.

## Timing
- Reset values (RST_N low at a CLK edge):
  - FSM to IDLE, `hit_acc` and `hit` to 0, `busy` to 0.
  - `car_x1`..`car_x6` to 0/100/200/300/400/500.
  - `car_x7`, `car_x8` are always H_DISPLAY.
- Reset mid-sequence aborts it: positions return to their reset values and no `hit` pulse is emitted.
- Tick sampled at edge T; the edges below are relative to T:
  - `busy` = 1 from T+1 through T+13.
  - `car_x(k+1)` updates at edge T+1+k (T+1..T+6).
  - CHECK runs at T+7..T+12.
  - `hit` is valid during T+13..T+14, and `busy` returns to 0 at T+14.
- Total of 13 busy cycles, which is far shorter than vblank.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset: hold RST_N=0 for 2 cycles. Expect `car_x1..6` = 0,100,200,300,400,500; `car_x7/8` = 640; `hit` = 0; `busy` = 0.
- One tick, level=0, enable=1:
  - Expect `car_x1..6` = 1,98,201,297,402,499.
  - Expect `busy` high for exactly 13 cycles.
  - Expect `car_x1` to change 1 cycle after the tick.
- Wrap:
  - Force lane 4 to x=1 with level=3. One tick gives 1 < 6, so x = 1+640-6 = 635.
  - Lane 1 at x=639 with level=0 gives x=0.
- Collision: player at (0,80), lane 1 at x=0. After a tick, expect `hit`=1 at T+13 for one cycle only. Move the player to y=200 and expect no pulse on the next tick.
- Freeze: with enable=0, apply 3 ticks. Expect positions unchanged, `busy` never asserted, `hit` stays 0.
- Reset mid-MOVE: assert RST_N=0 at T+3. Expect all positions at their reset values, FSM in IDLE, and no `hit` pulse.
